// File: rtl/piso_tx_stream.sv
// piso_tx_stream: parameterised parallel-in serial-out transmitter.
// Words arrive on a valid/ready handshake. One word can wait in a holding
// register while the shifter streams the current word, so consecutive
// words go out back-to-back with no idle bit between them.
//
// Handshake: a word transfers on a rising edge where i_data_valid and
// o_data_ready are both high. o_data_ready depends only on hold_full and
// i_reset, never on i_data_valid. A word offered while ready is low is
// ignored; the producer must keep offering it until ready is high.
module piso_tx_stream #(
    parameter int   DATA_W     = 10,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_data_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_data_ready,
    output logic              o_serial_data,
    output logic              o_serial_valid,
    output logic              o_tx_done,
    output logic              o_busy
);

    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [DATA_W-1:0] hold_q, hold_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              hold_full_q, hold_full_n;
    logic              sdata_q, sdata_n;
    logic              svalid_q, svalid_n;
    logic              done_q, done_n;
    logic              accept, last_bit;
    logic [DATA_W-1:0] ord_in, ord_hold;

    // Rearrange a word so bit 0 is always the first bit to send; the
    // shifter then only ever shifts right.
    function automatic logic [DATA_W-1:0] to_order(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = MSB_FIRST ? w[DATA_W-1-i] : w[i];
        end
        return r;
    endfunction

    assign o_data_ready   = !hold_full_q && !i_reset;
    assign accept         = i_data_valid && o_data_ready;
    assign last_bit       = (cnt_q == LAST);
    assign ord_in         = to_order(i_data);
    assign ord_hold       = to_order(hold_q);
    assign o_serial_data  = sdata_q;
    assign o_serial_valid = svalid_q;
    assign o_tx_done      = done_q;
    assign o_busy         = (state == SHIFT) || hold_full_q;

    // Next-state and next-output logic for the shifter and holding register.
    always_comb begin
        state_n     = state;
        shift_n     = shift_q;
        hold_n      = hold_q;
        cnt_n       = cnt_q;
        hold_full_n = hold_full_q;
        sdata_n     = IDLE_LEVEL;
        svalid_n    = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                // Hold is always empty here; the word goes straight to the shifter.
                if (accept) begin
                    state_n  = SHIFT;
                    shift_n  = ord_in >> 1;
                    sdata_n  = ord_in[0];
                    svalid_n = 1'b1;
                    cnt_n    = '0;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shift_n  = shift_q >> 1;
                    sdata_n  = shift_q[0];
                    svalid_n = 1'b1;
                    cnt_n    = cnt_q + CNT_W'(1);
                    done_n   = ((cnt_q + CNT_W'(1)) == LAST);
                    if (accept) begin
                        hold_n      = i_data;
                        hold_full_n = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Ready is low while hold is full, so nothing is accepted here.
                    shift_n     = ord_hold >> 1;
                    sdata_n     = ord_hold[0];
                    svalid_n    = 1'b1;
                    cnt_n       = '0;
                    hold_full_n = 1'b0;
                end else if (accept) begin
                    // Word arriving exactly on the last bit keeps the stream seamless.
                    shift_n  = ord_in >> 1;
                    sdata_n  = ord_in[0];
                    svalid_n = 1'b1;
                    cnt_n    = '0;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; reset discards both the word in flight and the held word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            sdata_q     <= IDLE_LEVEL;
            svalid_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            shift_q     <= shift_n;
            hold_q      <= hold_n;
            cnt_q       <= cnt_n;
            hold_full_q <= hold_full_n;
            sdata_q     <= sdata_n;
            svalid_q    <= svalid_n;
            done_q      <= done_n;
        end
    end

endmodule
